// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz raster constants for the sync generator and its consumers.
package vga_timing_pkg;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int X_WIDTH       = 10;
    localparam int Y_WIDTH       = 9;
    localparam int H_COUNT_WIDTH = 11;
    localparam int V_COUNT_WIDTH = 10;

    localparam logic VGA_SYNC_ACTIVE_LEVEL = 1'b0;

    // Registered per-pixel outputs, updated together on each pixel advance.
    typedef struct packed {
        logic               hsync;
        logic               vsync;
        logic               inside_video;
        logic [X_WIDTH-1:0] x;
        logic [Y_WIDTH-1:0] y;
    } raster_out_t;

endpackage

// File: rtl/pixel_tick_divider.sv
// Board-clock divider; pixel_tick flags the clock whose closing edge advances the raster.
module pixel_tick_divider #(
    parameter int CLOCK_DIVIDE = 2
) (
    input  logic clock,
    input  logic reset_n,
    output logic pixel_tick
);

    localparam int DIV_W = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCK_DIVIDE - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Decoded from the counter register; the top registers it alongside the raster state.
    assign pixel_tick = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_sync_generator.sv
// VGA raster timing: sync pulses, pixel coordinates and visibility, all registered with zero lag.
module vga_sync_generator
    import vga_timing_pkg::*;
#(
    parameter int   CLOCK_DIVIDE      = 2,
    parameter int   H_VISIBLE         = VGA_H_VISIBLE,
    parameter int   H_FRONT           = VGA_H_FRONT,
    parameter int   H_SYNC            = VGA_H_SYNC,
    parameter int   H_BACK            = VGA_H_BACK,
    parameter int   V_VISIBLE         = VGA_V_VISIBLE,
    parameter int   V_FRONT           = VGA_V_FRONT,
    parameter int   V_SYNC            = VGA_V_SYNC,
    parameter int   V_BACK            = VGA_V_BACK,
    parameter logic SYNC_ACTIVE_LEVEL = VGA_SYNC_ACTIVE_LEVEL
) (
    input  logic               clock,
    input  logic               reset_n,
    output logic               pixel_tick,
    output logic               hsync,
    output logic               vsync,
    output logic [X_WIDTH-1:0] x_position,
    output logic [Y_WIDTH-1:0] y_position,
    output logic               inside_video,
    output logic               frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [H_COUNT_WIDTH-1:0] H_LAST       = H_COUNT_WIDTH'(H_TOTAL - 1);
    localparam logic [H_COUNT_WIDTH-1:0] H_VIS_END    = H_COUNT_WIDTH'(H_VISIBLE);
    localparam logic [H_COUNT_WIDTH-1:0] H_SYNC_START = H_COUNT_WIDTH'(H_VISIBLE + H_FRONT);
    localparam logic [H_COUNT_WIDTH-1:0] H_SYNC_END   = H_COUNT_WIDTH'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [V_COUNT_WIDTH-1:0] V_LAST       = V_COUNT_WIDTH'(V_TOTAL - 1);
    localparam logic [V_COUNT_WIDTH-1:0] V_VIS_END    = V_COUNT_WIDTH'(V_VISIBLE);
    localparam logic [V_COUNT_WIDTH-1:0] V_SYNC_START = V_COUNT_WIDTH'(V_VISIBLE + V_FRONT);
    localparam logic [V_COUNT_WIDTH-1:0] V_SYNC_END   = V_COUNT_WIDTH'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam raster_out_t RASTER_RESET = '{
        hsync:        ~SYNC_ACTIVE_LEVEL,
        vsync:        ~SYNC_ACTIVE_LEVEL,
        inside_video: 1'b0,
        x:            '0,
        y:            '0
    };

    logic                     advance;
    logic [H_COUNT_WIDTH-1:0] h_count_q, h_count_d;
    logic [V_COUNT_WIDTH-1:0] v_count_q, v_count_d;
    raster_out_t              raster_q, raster_d;
    logic                     pixel_tick_q, pixel_tick_d;
    logic                     frame_start_q, frame_start_d;

    pixel_tick_divider #(
        .CLOCK_DIVIDE (CLOCK_DIVIDE)
    ) u_divider (
        .clock      (clock),
        .reset_n    (reset_n),
        .pixel_tick (advance)
    );

    // Outputs are decoded from the next counter values so they land in the same cycle as the counters.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        h_count_d     = h_count_q;
        v_count_d     = v_count_q;
        raster_d      = raster_q;
        pixel_tick_d  = advance;
        frame_start_d = 1'b0;

        if (advance) begin
            h_count_d = (h_count_q == H_LAST) ? '0 : h_count_q + 1'b1;
            if (h_count_q == H_LAST) begin
                v_count_d = (v_count_q == V_LAST) ? '0 : v_count_q + 1'b1;
            end

            raster_d.inside_video = (h_count_d < H_VIS_END) && (v_count_d < V_VIS_END);
            raster_d.hsync = ((h_count_d >= H_SYNC_START) && (h_count_d < H_SYNC_END))
                             ? SYNC_ACTIVE_LEVEL : ~SYNC_ACTIVE_LEVEL;
            raster_d.vsync = ((v_count_d >= V_SYNC_START) && (v_count_d < V_SYNC_END))
                             ? SYNC_ACTIVE_LEVEL : ~SYNC_ACTIVE_LEVEL;
            raster_d.x = raster_d.inside_video ? h_count_d[X_WIDTH-1:0] : '0;
            raster_d.y = raster_d.inside_video ? v_count_d[Y_WIDTH-1:0] : '0;
            frame_start_d = (h_count_d == '0) && (v_count_d == '0);
        end
    end

    // Counters park on the last raster position so the first advance lands on (0,0).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h_count_q     <= H_LAST;
            v_count_q     <= V_LAST;
            raster_q      <= RASTER_RESET;
            pixel_tick_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_count_q     <= h_count_d;
            v_count_q     <= v_count_d;
            raster_q      <= raster_d;
            pixel_tick_q  <= pixel_tick_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pixel_tick   = pixel_tick_q;
    assign hsync        = raster_q.hsync;
    assign vsync        = raster_q.vsync;
    assign x_position   = raster_q.x;
    assign y_position   = raster_q.y;
    assign inside_video = raster_q.inside_video;
    assign frame_start  = frame_start_q;

endmodule
